// File: rtl/cram_write_arb.sv
// cram_write_arb: arbitrates CPU, DMA and fill-engine writes into the CRAM
// write port. One write at most per c3 slot, priority CPU > DMA > fill.
// The CRAM port signals, dma_ack and the fill state are all registered.
module cram_write_arb #(
   parameter int ADDRWIDTH = 8,
   parameter int DATAWIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 c3,
   input  logic                 cpu_we,
   input  logic [ADDRWIDTH-1:0] cpu_addr,
   input  logic [DATAWIDTH-1:0] cpu_data,
   output logic                 cpu_busy,
   input  logic                 dma_req,
   input  logic [ADDRWIDTH-1:0] dma_addr,
   input  logic [DATAWIDTH-1:0] dma_data,
   output logic                 dma_ack,
   input  logic                 clr_start,
   input  logic [DATAWIDTH-1:0] clr_data,
   output logic                 clr_busy,
   output logic [ADDRWIDTH-1:0] cram_addr,
   output logic [DATAWIDTH-1:0] cram_data,
   output logic                 cram_we
);

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } fill_state_t;

   localparam logic [ADDRWIDTH-1:0] LAST_ENTRY = '1;
   localparam logic [ADDRWIDTH-1:0] ADDR_ONE   = ADDRWIDTH'(1);

   fill_state_t          state_q, state_d;
   logic [ADDRWIDTH-1:0] fill_cnt_q, fill_cnt_d;

   logic                 pending;
   logic [ADDRWIDTH-1:0] hold_addr;
   logic [DATAWIDTH-1:0] hold_data;

   logic                 dma_ready;
   logic                 cpu_grant;
   logic                 dma_grant;
   logic                 fill_grant;

   assign cpu_busy = pending;
   assign clr_busy = (state_q == FILL);

   // Slot grant: strict priority, evaluated only when c3 is high.
   // A DMA request whose ack is still showing has already been served.
   // A restart arriving in a slot leaves that slot unused by the fill,
   // so the first write after a restart always goes to entry 0.
   always_comb begin
      dma_ready  = dma_req && !dma_ack;
      cpu_grant  = c3 && pending;
      dma_grant  = c3 && !pending && dma_ready;
      fill_grant = c3 && !pending && !dma_ready && (state_q == FILL) && !clr_start;
   end

   // CPU holding register: last write wins; a capture coinciding with a
   // drain keeps the register occupied with the new word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending   <= 1'b0;
         hold_addr <= '0;
         hold_data <= '0;
      end else if (cpu_we) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge values, independent of block order.
         pending   <= 1'b1;
         hold_addr <= cpu_addr;
         hold_data <= cpu_data;
      end else if (cpu_grant) begin
         pending   <= 1'b0;
      end
   end

   // Fill engine next state: restart wins, otherwise step on each own slot.
   always_comb begin
      // NOTE: defaults first, so no path leaves a variable unassigned and
      // no latch is inferred.
      state_d    = state_q;
      fill_cnt_d = fill_cnt_q;
      if (clr_start) begin
         state_d    = FILL;
         fill_cnt_d = '0;
      end else if (fill_grant) begin
         fill_cnt_d = fill_cnt_q + ADDR_ONE;
         if (fill_cnt_q == LAST_ENTRY) begin
            state_d = IDLE;
         end
      end
   end

   // Fill engine state and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         fill_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         fill_cnt_q <= fill_cnt_d;
      end
   end

   // CRAM port and DMA ack registers: one-clk strobes, address/data hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cram_we   <= 1'b0;
         cram_addr <= '0;
         cram_data <= '0;
         dma_ack   <= 1'b0;
      end else begin
         cram_we <= cpu_grant || dma_grant || fill_grant;
         dma_ack <= dma_grant;
         if (cpu_grant) begin
            cram_addr <= hold_addr;
            cram_data <= hold_data;
         end else if (dma_grant) begin
            cram_addr <= dma_addr;
            cram_data <= dma_data;
         end else if (fill_grant) begin
            cram_addr <= fill_cnt_q;
            cram_data <= clr_data;
         end
      end
   end

endmodule
